// File: rtl/shift_piso.sv
`default_nettype none
// ============================================================================
// Module   : shift_piso
// Purpose  : Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word on
//            a valid/ready handshake and emits it one bit per clock, with
//            out_valid, frame_start and done qualifiers.
//            Define PARITY_EN to append an even-parity bit to every frame.
// Revision : 1.0 - initial release
// ============================================================================
module shift_piso #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned MSB_FIRST  = 0,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             done
);

`ifdef PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif
    localparam int unsigned      CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             done_q, done_d;

    logic             head_bit;
    logic [WIDTH-1:0] shreg_shifted;
    logic             tx_bit;
    logic             last_bit;
    logic             handshake;

    // The bit leaving next and the register after it has gone, per bit order.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign head_bit      = shreg_q[WIDTH-1];
            assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign head_bit      = shreg_q[0];
            assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

`ifdef PARITY_EN
    logic parity_q, parity_d;
    // Once all data bits are out, the counter points at the parity slot.
    assign tx_bit = (cnt_q == CNT_W'(WIDTH)) ? parity_q : head_bit;
`else
    assign tx_bit = head_bit;
`endif

    // The FSM runs one cycle ahead of the registered outputs, so accepting a
    // word during the final SHIFT cycle lets the next frame follow gap-free.
    assign last_bit   = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
    assign load_ready = rst_n && ((state_q == ST_IDLE) || last_bit);
    assign handshake  = load_valid && load_ready;

    // Next-state logic and next values of the registered serial outputs.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        cnt_d         = cnt_q;
        out_d         = IDLE_LEVEL;
        out_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        done_d        = 1'b0;
`ifdef PARITY_EN
        parity_d      = parity_q;
`endif
        if (state_q == ST_SHIFT) begin
            out_d         = tx_bit;
            out_valid_d   = 1'b1;
            frame_start_d = (cnt_q == '0);
            done_d        = last_bit;
            shreg_d       = shreg_shifted;
            cnt_d         = cnt_q + CNT_W'(1);
            if (last_bit) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end
        if (handshake) begin
            state_d  = ST_SHIFT;
            shreg_d  = load_data;
            cnt_d    = '0;
`ifdef PARITY_EN
            parity_d = ^load_data;
`endif
        end
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            cnt_q         <= '0;
            out_q         <= IDLE_LEVEL;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
`ifdef PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            frame_start_q <= frame_start_d;
            done_q        <= done_d;
`ifdef PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    assign out         = out_q;
    assign out_valid   = out_valid_q;
    assign frame_start = frame_start_q;
    assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_piso.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_piso
// Purpose  : Self-checking bench for shift_piso. One instance sends LSB first,
//            a second sends MSB first; both share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_piso;

`ifdef PARITY_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    // Expected serial streams are written in time order, left to right;
    // the fifth position is the parity bit and only matters with PARITY_EN.
    typedef struct {
        logic [3:0] data;
        logic [0:4] seq_l;
        logic [0:4] seq_m;
    } vec_t;

    vec_t tbl [9];

    logic       clk;
    logic       rst_n;
    logic       load_valid;
    logic [3:0] load_data;
    logic       ready0, out0, ov0, fs0, dn0;
    logic       ready1, out1, ov1, fs1, dn1;

    int n_checks = 0;
    int n_errors = 0;

    shift_piso #(.WIDTH(4), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_valid  (load_valid),
        .load_ready  (ready0),
        .load_data   (load_data),
        .out         (out0),
        .out_valid   (ov0),
        .frame_start (fs0),
        .done        (dn0)
    );

    shift_piso #(.WIDTH(4), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_valid  (load_valid),
        .load_ready  (ready1),
        .load_data   (load_data),
        .out         (out1),
        .out_valid   (ov1),
        .frame_start (fs1),
        .done        (dn1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_cycle(input string tag, input logic ov, input logic o0,
                             input logic o1, input logic fs, input logic dn,
                             input logic rdy);
        chk({tag, " lsb out_valid"},   ov0,    ov);
        chk({tag, " msb out_valid"},   ov1,    ov);
        chk({tag, " lsb out"},         out0,   o0);
        chk({tag, " msb out"},         out1,   o1);
        chk({tag, " lsb frame_start"}, fs0,    fs);
        chk({tag, " msb frame_start"}, fs1,    fs);
        chk({tag, " lsb done"},        dn0,    dn);
        chk({tag, " msb done"},        dn1,    dn);
        chk({tag, " lsb load_ready"},  ready0, rdy);
        chk({tag, " msb load_ready"},  ready1, rdy);
    endtask

    // Called at a negedge; returns at a negedge with both instances ready.
    task automatic wait_ready();
        int n = 0;
        while (!(ready0 && ready1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: actual=load_ready low expected=high within 20 cycles");
        end
    endtask

    // Observes one frame whose handshake is at the next posedge. Inputs are
    // held valid with garbage data during the busy cycles to show they are
    // ignored, then released before the last-bit cycle can accept them.
    task automatic observe(input string tag, input logic [3:0] d,
                           input logic [0:4] sl, input logic [0:4] sm);
        @(negedge clk);
        for (int k = 0; k <= FL; k++) begin
            if (k > 0) @(negedge clk);
            chk_cycle($sformatf("%s k%0d", tag, k), k >= 1,
                      (k >= 1) ? sl[k-1] : 1'b0,
                      (k >= 1) ? sm[k-1] : 1'b0,
                      k == 1, k == FL, k >= FL - 1);
            load_valid = (k < FL - 1);
            load_data  = ~d;
        end
        load_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input vec_t v);
        wait_ready();
        load_valid = 1'b1;
        load_data  = v.data;
        observe(tag, v.data, v.seq_l, v.seq_m);
    endtask

    initial begin
        logic [3:0] sipo;
        logic [3:0] w;
        int         f;
        int         j;

        tbl[0] = '{4'b1011, 5'b11011, 5'b10111};
        tbl[1] = '{4'b1000, 5'b00011, 5'b10001};
        tbl[2] = '{4'b1010, 5'b01010, 5'b10100};
        tbl[3] = '{4'b0101, 5'b10100, 5'b01010};
        tbl[4] = '{4'b0111, 5'b11101, 5'b01111};
        tbl[5] = '{4'b0011, 5'b11000, 5'b00110};
        tbl[6] = '{4'b1111, 5'b11110, 5'b11110};
        tbl[7] = '{4'b0000, 5'b00000, 5'b00000};
        tbl[8] = '{4'b1100, 5'b00110, 5'b11000};

        // Reset held with a pending word: nothing may start.
        rst_n      = 1'b0;
        load_valid = 1'b1;
        load_data  = 4'hF;
        repeat (3) begin
            @(negedge clk);
            chk_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        #1;
        chk("release lsb load_ready", ready0, 1'b1);
        chk("release msb load_ready", ready1, 1'b1);
        // The word held through reset is taken at the first edge after release.
        observe("post_release", 4'hF, tbl[6].seq_l, tbl[6].seq_m);

        // Directed single frames.
        for (int i = 0; i < 9; i++)
            run_frame($sformatf("vec%0d", i), tbl[i]);

        // Back-to-back 4'hA then 4'h5 with load_valid held.
        wait_ready();
        load_valid = 1'b1;
        load_data  = 4'hA;
        @(negedge clk);
        for (int k = 0; k <= 2 * FL; k++) begin
            if (k > 0) @(negedge clk);
            f = (k >= 1) ? (k - 1) / FL : 0;
            j = (k >= 1) ? (k - 1) % FL : 0;
            chk_cycle($sformatf("b2b k%0d", k), k >= 1,
                      (k >= 1) ? ((f == 0) ? tbl[2].seq_l[j] : tbl[3].seq_l[j]) : 1'b0,
                      (k >= 1) ? ((f == 0) ? tbl[2].seq_m[j] : tbl[3].seq_m[j]) : 1'b0,
                      (k == 1) || (k == FL + 1),
                      (k == FL) || (k == 2 * FL),
                      (k == FL - 1) || (k == 2 * FL - 1) || (k == 2 * FL));
            if (k == 0) load_data = 4'h5;
            if (k == FL) load_valid = 1'b0;
        end

        // Reset after the second bit of 4'hF aborts the frame.
        wait_ready();
        load_valid = 1'b1;
        load_data  = 4'hF;
        @(negedge clk);
        load_valid = 1'b0;
        @(negedge clk);
        chk_cycle("midrst bit1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_cycle("midrst bit2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_cycle("midrst async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk_cycle("midrst held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_cycle("midrst idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        run_frame("after_rst", tbl[5]);

        // Loopback into a 4-bit SIPO packing {newest..oldest}.
        for (int i = 0; i < 64; i++) begin
            w    = 4'($urandom_range(0, 15));
            sipo = 4'h0;
            wait_ready();
            load_valid = 1'b1;
            load_data  = w;
            @(negedge clk);
            load_valid = 1'b0;
            for (int k = 1; k <= FL; k++) begin
                @(negedge clk);
                if (k <= 4 && ov0) sipo = {out0, sipo[3:1]};
            end
            chk4($sformatf("loopback %0d", i), sipo, w);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
